// File: rtl/score_row_buffer.sv
// Row-major score buffer between the output-layer MAC and the argmax stage.
// Optional macro SCORE_RELU_EN: clamp negative (MSB=1) scores to zero on write.
module score_row_buffer #(
    parameter int NUM_ROWS = 6,
    parameter int NUM_COLS = 3,
    parameter int DATA_W   = 16,
    parameter int ROW_AW   = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic [ROW_AW-1:0] read_row,
    output logic [DATA_W-1:0] row [0:NUM_COLS-1],
    output logic              consumer_en,
    input  logic              consumer_done,
    output logic [7:0]        frame_count,
    output logic [1:0]        dbg_state
);

    localparam int COL_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;

    typedef enum logic [1:0] {
        S_FILL     = 2'd0,
        S_SERVE    = 2'd1,
        S_WAIT_CLR = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [ROW_AW-1:0]   r_row_cnt;
    logic [COL_W-1:0]    r_col_cnt;
    logic [7:0]          r_frame_count;
    logic [DATA_W-1:0]   r_mem [0:NUM_ROWS-1][0:NUM_COLS-1];

    logic                w_accept;
    logic                w_col_wrap;
    logic                w_last;
    logic                w_restart;
    logic [DATA_W-1:0]   w_wr_data;

    // Handshake: an element transfers on a rising edge where in_valid && in_ready.
    assign w_accept   = in_valid && (r_state == S_FILL);
    assign w_col_wrap = (r_col_cnt == COL_W'(NUM_COLS - 1));
    assign w_last     = w_accept && w_col_wrap && (r_row_cnt == ROW_AW'(NUM_ROWS - 1));
    assign w_restart  = (r_state == S_WAIT_CLR) && !consumer_done;

`ifdef SCORE_RELU_EN
    assign w_wr_data = in_data[DATA_W-1] ? '0 : in_data;
`else
    assign w_wr_data = in_data;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        consumer_en  = 1'b0;
        case (r_state)
            S_FILL: begin
                in_ready = 1'b1;
                if (w_last) w_next_state = S_SERVE;
            end
            S_SERVE: begin
                consumer_en = 1'b1;
                if (consumer_done) w_next_state = S_WAIT_CLR;
            end
            S_WAIT_CLR: begin
                // The consumer's done is sticky; wait for its reset before refilling.
                if (!consumer_done) w_next_state = S_FILL;
            end
            default: w_next_state = S_FILL;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_row_cnt     <= '0;
            r_col_cnt     <= '0;
            r_frame_count <= '0;
        end else begin
            if (w_last || w_restart) begin
                r_row_cnt <= '0;
                r_col_cnt <= '0;
            end else if (w_accept) begin
                if (w_col_wrap) begin
                    r_col_cnt <= '0;
                    r_row_cnt <= r_row_cnt + 1'b1;
                end else begin
                    r_col_cnt <= r_col_cnt + 1'b1;
                end
            end
            if (r_state == S_SERVE && consumer_done) begin
                r_frame_count <= r_frame_count + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NUM_ROWS; r++) begin
                for (int c = 0; c < NUM_COLS; c++) begin
                    r_mem[r][c] <= '0;
                end
            end
        end else if (w_accept) begin
            r_mem[r_row_cnt][r_col_cnt] <= w_wr_data;
        end
    end

    // Out-of-range addresses (the consumer's final cycle) read as zero.
    always_comb begin
        for (int c = 0; c < NUM_COLS; c++) begin
            row[c] = '0;
            if (read_row < ROW_AW'(NUM_ROWS)) begin
                row[c] = r_mem[read_row][c];
            end
        end
    end

    assign frame_count = r_frame_count;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_score_row_buffer.sv
// Self-checking bench for score_row_buffer: vector table plus expected-score queue.
module tb_score_row_buffer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_ready;
    logic [2:0]  read_row = '0;
    logic [15:0] row [0:2];
    logic        consumer_en;
    logic        consumer_done = 1'b0;
    logic [7:0]  frame_count;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] exp_q[$];

    typedef struct {
        string       name;
        logic [2:0]  addr;
        logic [15:0] e0;
        logic [15:0] e1;
        logic [15:0] e2;
    } vec_t;

    vec_t vecs_f1 [6];
    vec_t vec_f2;
    vec_t vec_relu;

    score_row_buffer dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .read_row      (read_row),
        .row           (row),
        .consumer_en   (consumer_en),
        .consumer_done (consumer_done),
        .frame_count   (frame_count),
        .dbg_state     (dbg_state)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] model(input logic [15:0] d);
`ifdef SCORE_RELU_EN
        return d[15] ? 16'h0000 : d;
`else
        return d;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic send_word(input logic [15:0] d, input bit toggle);
        if (toggle) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1 chk("in_ready_idle", in_ready, 1);
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        #1 chk("in_ready_fill", in_ready, 1);
        exp_q.push_back(model(d));
    endtask

    task automatic end_frame();
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("in_ready_serve", in_ready, 0);
        chk("consumer_en_serve", consumer_en, 1);
        chk("state_serve", dbg_state, 2'd1);
    endtask

    task automatic send_frame(input logic [15:0] base, input bit toggle);
        for (int i = 0; i < 18; i++) send_word(base + 16'(i), toggle);
        end_frame();
    endtask

    task automatic check_vec(input vec_t v);
        @(negedge clk);
        read_row = v.addr;
        #1;
        chk({v.name, "_c0"}, row[0], v.e0);
        chk({v.name, "_c1"}, row[1], v.e1);
        chk({v.name, "_c2"}, row[2], v.e2);
    endtask

    task automatic check_frame();
        for (int r = 0; r < 6; r++) begin
            @(negedge clk);
            read_row = 3'(r);
            #1;
            for (int c = 0; c < 3; c++) begin
                if (exp_q.size() == 0) begin
                    chk("sb_underflow", 1, 0);
                end else begin
                    chk($sformatf("sb_r%0d_c%0d", r, c), row[c], exp_q.pop_front());
                end
            end
        end
        chk("sb_leftover", exp_q.size(), 0);
    endtask

    task automatic done_sequence(input logic [7:0] exp_fc);
        @(negedge clk);
        consumer_done = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            chk("en_after_done", consumer_en, 0);
            chk("in_ready_wait", in_ready, 0);
            chk("frame_count", frame_count, exp_fc);
        end
        consumer_done = 1'b0;
        @(negedge clk);
        #1;
        chk("in_ready_refill", in_ready, 1);
        chk("state_fill", dbg_state, 2'd0);
    endtask

    initial begin
        vecs_f1[0] = '{"f1_row0", 3'd0, 16'd1,  16'd2,  16'd3};
        vecs_f1[1] = '{"f1_row5", 3'd5, 16'd16, 16'd17, 16'd18};
        vecs_f1[2] = '{"f1_row2", 3'd2, 16'd7,  16'd8,  16'd9};
        vecs_f1[3] = '{"f1_row6", 3'd6, 16'd0,  16'd0,  16'd0};
        vecs_f1[4] = '{"f1_row7", 3'd7, 16'd0,  16'd0,  16'd0};
        vecs_f1[5] = '{"f1_row3", 3'd3, 16'd10, 16'd11, 16'd12};
        vec_f2     = '{"f2_row2", 3'd2, 16'd106, 16'd107, 16'd108};
`ifdef SCORE_RELU_EN
        vec_relu   = '{"relu_row0", 3'd0, 16'h0000, 16'h0005, 16'h0000};
`else
        vec_relu   = '{"relu_row0", 3'd0, 16'hFFFF, 16'h0005, 16'h8000};
`endif

        // Reset state
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_consumer_en", consumer_en, 0);
        chk("rst_frame_count", frame_count, 0);
        chk("rst_state", dbg_state, 2'd0);
        chk("rst_row0", row[0], 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Frame 1: back-to-back 1..18
        send_frame(16'd1, 1'b0);
        for (int i = 0; i < 6; i++) check_vec(vecs_f1[i]);
        // Stray valids in SERVE must not touch storage
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 16'hDEAD;
        repeat (2) @(negedge clk);
        #1 chk("in_ready_serve_hold", in_ready, 0);
        in_valid = 1'b0;
        check_frame();
        done_sequence(8'd1);

        // Frame 2: toggling valid, 100..117
        send_frame(16'd100, 1'b1);
        check_vec(vec_f2);
        check_frame();
        done_sequence(8'd2);

        // Reset after 7 elements
        for (int i = 0; i < 7; i++) send_word(16'd50 + 16'(i), 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b1;
        #1;
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_en", consumer_en, 0);
        chk("mid_rst_frame_count", frame_count, 0);
        chk("mid_rst_state", dbg_state, 2'd0);
        read_row = 3'd0;
        #1 chk("mid_rst_row0", row[0], 0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 18; i++) send_word(16'($urandom_range(0, 16'h7FFF)), 1'b0);
        end_frame();
        check_frame();
        done_sequence(8'd1);

        // Negative-score handling in row 0
        send_word(16'hFFFF, 1'b0);
        send_word(16'h0005, 1'b0);
        send_word(16'h8000, 1'b0);
        for (int i = 0; i < 15; i++) send_word(16'($urandom_range(0, 16'hFFFF)), 1'b0);
        end_frame();
        check_vec(vec_relu);
        check_frame();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
